airlock_pressurize: RTL and testbench



---
 rtl/airlock_pressurize_if.sv | 25 ++
 rtl/airlock_pressurize.sv | 121 ++++++++++++
 tb/tb_airlock_pressurize.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/airlock_pressurize_if.sv
// Airlock pressurization status/control bundle.
// Master side drives the request and door/vacuum status lines and observes the
// controller outputs. Slave side is the pressurization controller.
interface airlock_pressurize_if #(
    parameter int CNT_W = 4
);
    logic             begin_Pressurization;
    logic             InnerClosed;
    logic             OuterClosed;
    logic             Evacuated;
    logic             Pressurization;
    logic             Pressurized;
    logic             Aborted;
    logic [CNT_W-1:0] Progress;

    modport master (
        output begin_Pressurization, InnerClosed, OuterClosed, Evacuated,
        input  Pressurization, Pressurized, Aborted, Progress
    );

    modport slave (
        input  begin_Pressurization, InnerClosed, OuterClosed, Evacuated,
        output Pressurization, Pressurized, Aborted, Progress
    );
endinterface

// File: rtl/airlock_pressurize.sv
// Airlock chamber pressurization controller.
// Opens the fill valve only from a sealed, evacuated chamber, times the fill in
// prescaled ticks, then reports pressurized. Any door opening mid-fill aborts.
// Optional build macro PRESSURIZE_DEBOUNCE_EN: a door-open condition must be seen
// on two consecutive FILL cycles before the fill aborts.
module airlock_pressurize #(
    parameter int TICK_DIV   = 4,
    parameter int FILL_TICKS = 7,
    parameter int CNT_W      = 4
) (
    input logic                 Clock,
    input logic                 Reset,
    airlock_pressurize_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [CNT_W-1:0] prog,  prog_nx;

    logic door_open;
    logic start;
    logic wrap;
    logic last;
    logic abort_go;

    assign door_open = !bus.InnerClosed || !bus.OuterClosed;
    assign start     = bus.begin_Pressurization && bus.InnerClosed &&
                       bus.OuterClosed && bus.Evacuated;
    assign wrap      = (presc == PW'(TICK_DIV - 1));
    assign last      = wrap && (prog == CNT_W'(FILL_TICKS - 1));

`ifdef PRESSURIZE_DEBOUNCE_EN
    // Remembers that the previous FILL cycle already saw a door open.
    logic dbnc, dbnc_nx;
    assign abort_go = door_open && dbnc;

    // Debounce flag register; cleared by reset and whenever not counting in FILL.
    always_ff @(posedge Clock) begin
        if (!Reset) dbnc <= 1'b0;
        else        dbnc <= dbnc_nx;
    end
`else
    assign abort_go = door_open;
`endif

    // State, prescaler and progress registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_IDLE;
            presc <= '0;
            prog  <= '0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            prog  <= prog_nx;
        end
    end

    // Next-state: fill timing, abort priority over completion, exit conditions.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        prog_nx  = prog;
`ifdef PRESSURIZE_DEBOUNCE_EN
        dbnc_nx  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FILL;
                    presc_nx = '0;
                    prog_nx  = '0;
                end
            end
            S_FILL: begin
                if (abort_go) begin
                    // Progress freezes at its value on the abort edge.
                    state_nx = S_ABORT;
                end else begin
                    presc_nx = wrap ? '0 : presc + 1'b1;
                    if (wrap) prog_nx = prog + 1'b1;
                    if (last) state_nx = S_FULL;
`ifdef PRESSURIZE_DEBOUNCE_EN
                    dbnc_nx = door_open;
`endif
                end
            end
            S_FULL: begin
                if (bus.Evacuated) begin
                    state_nx = S_IDLE;
                    prog_nx  = '0;
                end
            end
            S_ABORT: begin
                // A held request must drop before the chamber can re-arm.
                if (!bus.begin_Pressurization && !door_open) begin
                    state_nx = S_IDLE;
                    prog_nx  = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                presc_nx = '0;
                prog_nx  = '0;
            end
        endcase
    end

    assign bus.Pressurization = (state == S_FILL);
    assign bus.Pressurized    = (state == S_FULL);
    assign bus.Aborted        = (state == S_ABORT);
    assign bus.Progress       = prog;
endmodule

// File: tb/tb_airlock_pressurize.sv
// Directed bench for airlock_pressurize with hand-computed expectations.
// Honours PRESSURIZE_DEBOUNCE_EN so the same bench covers both builds.
module tb_airlock_pressurize;
    logic Clock;
    logic Reset;
    int   n_chk;
    int   n_err;
    int   hi_cnt;

    airlock_pressurize_if #(.CNT_W(4)) bus ();

    airlock_pressurize #(.TICK_DIV(4), .FILL_TICKS(7), .CNT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge; sample/drive 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic pz, input logic fl,
                           input logic ab, input logic [3:0] pg);
        chk({tag, ".valve"}, bus.Pressurization, pz);
        chk({tag, ".full"},  bus.Pressurized,    fl);
        chk({tag, ".abort"}, bus.Aborted,        ab);
        chk({tag, ".prog"},  bus.Progress,       pg);
    endtask

    // Enter FILL with a one-cycle request pulse; vacuum line dropped afterwards.
    task automatic start_fill();
        bus.Evacuated = 1'b1;
        bus.begin_Pressurization = 1'b1;
        step();
        bus.begin_Pressurization = 1'b0;
        bus.Evacuated = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        Reset = 1'b0;
        bus.begin_Pressurization = 1'b0;
        bus.InnerClosed = 1'b1;
        bus.OuterClosed = 1'b1;
        bus.Evacuated   = 1'b0;
        step(); step();
        Reset = 1'b1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 4'd0);

        // Nominal fill: 28 valve cycles, progress every 4 cycles.
        start_fill();
        hi_cnt = 0;
        chk_out("fill0", 1'b1, 1'b0, 1'b0, 4'd0);
        if (bus.Pressurization) hi_cnt++;
        for (int k = 1; k <= 28; k++) begin
            step();
            if (bus.Pressurization) hi_cnt++;
            if (k % 4 == 0 && k < 28) chk($sformatf("nom.prog%0d", k), bus.Progress, k / 4);
        end
        chk("nom.hicnt", hi_cnt, 28);
        chk_out("nom.full", 1'b0, 1'b1, 1'b0, 4'd7);
        step(); step();
        bus.InnerClosed = 1'b0;
        step();
        bus.InnerClosed = 1'b1;
        chk_out("nom.hold", 1'b0, 1'b1, 1'b0, 4'd7);
        bus.Evacuated = 1'b1;
        step();
        bus.Evacuated = 1'b0;
        chk_out("nom.idle", 1'b0, 1'b0, 1'b0, 4'd0);

        // Gating: outer door open, then chamber not evacuated.
        bus.begin_Pressurization = 1'b1;
        bus.OuterClosed = 1'b0;
        bus.Evacuated = 1'b1;
        step(); step(); step();
        chk("gate.outer", bus.Pressurization, 1'b0);
        bus.OuterClosed = 1'b1;
        bus.Evacuated = 1'b0;
        step(); step(); step();
        chk("gate.evac", bus.Pressurization, 1'b0);
        bus.begin_Pressurization = 1'b0;
        step();

        // One-cycle inner-door glitch sampled on fill edge 10.
        start_fill();
        for (int k = 1; k <= 10; k++) begin
            bus.InnerClosed = (k != 10);
            step();
        end
        bus.InnerClosed = 1'b1;
`ifdef PRESSURIZE_DEBOUNCE_EN
        chk_out("glitch.fill", 1'b1, 1'b0, 1'b0, 4'd2);
        for (int k = 11; k <= 28; k++) step();
        chk_out("glitch.full", 1'b0, 1'b1, 1'b0, 4'd7);
        bus.Evacuated = 1'b1;
        step();
        bus.Evacuated = 1'b0;
        chk_out("glitch.idle", 1'b0, 1'b0, 1'b0, 4'd0);
`else
        chk_out("abort10", 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        chk_out("abort10.exit", 1'b0, 1'b0, 1'b0, 4'd0);
`endif

        // Boundary: door open on the edge of the final tick wrap.
        start_fill();
        for (int k = 1; k <= 28; k++) begin
`ifdef PRESSURIZE_DEBOUNCE_EN
            bus.InnerClosed = !(k == 27 || k == 28);
`else
            bus.InnerClosed = (k != 28);
`endif
            step();
        end
        chk_out("bound", 1'b0, 1'b0, 1'b1, 4'd6);

        // Abort exit: held request stays, open door stays, then release.
        bus.begin_Pressurization = 1'b1;
        bus.InnerClosed = 1'b1;
        step(); step(); step();
        chk_out("abx.held", 1'b0, 1'b0, 1'b1, 4'd6);
        bus.begin_Pressurization = 1'b0;
        bus.OuterClosed = 1'b0;
        step();
        chk("abx.door", bus.Aborted, 1'b1);
        bus.OuterClosed = 1'b1;
        step();
        chk_out("abx.idle", 1'b0, 1'b0, 1'b0, 4'd0);

        // Reset mid-fill wins.
        start_fill();
        for (int k = 1; k <= 9; k++) step();
        chk("rst.pre", bus.Progress, 2);
        Reset = 1'b0;
        step(); step();
        Reset = 1'b1;
        chk_out("rst.mid", 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk_out("rst.post", 1'b0, 1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
